// File: rtl/fp16mul_pkg.sv
// Shared types, constants and operand-unpack helper for the FP16 x FP16 -> FP32 multiplier.
// Build option FP16MUL_SUBNORM_EN: normalise subnormal inputs instead of flushing them to zero.
package fp16mul_pkg;

  localparam int unsigned FP16_W      = 16;
  localparam int unsigned FP32_W      = 32;
  localparam int unsigned FP16_EXP_W  = 5;
  localparam int unsigned FP16_FRAC_W = 10;
  localparam int unsigned FP32_FRAC_W = 23;
  localparam logic [7:0]  BIAS_ADJ    = 8'd97;
  localparam logic [31:0] QNAN32      = 32'h7FC0_0000;

  typedef struct packed {
    logic                   sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_FRAC_W-1:0] frac;
  } fp16_t;

  typedef struct packed {
    logic                   sign;
    logic [7:0]             exp;
    logic [FP32_FRAC_W-1:0] frac;
  } fp32_t;

  // Classified operand; exp is a two's-complement biased exponent (negative for subnormals)
  typedef struct packed {
    logic                 sign;
    logic                 nan;
    logic                 inf;
    logic                 zero;
    logic [FP16_FRAC_W:0] sig;
    logic [7:0]           exp;
  } fp16_op_t;

`ifdef FP16MUL_SUBNORM_EN
  function automatic logic [3:0] lzc11(input logic [10:0] v);
    logic [3:0] z;
    logic       found;
    z     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 11; i++) begin
      if (!found) begin
        if (v[10-i]) found = 1'b1;
        else         z     = z + 4'd1;
      end
    end
    return z;
  endfunction
`endif

  function automatic fp16_op_t unpack_fp16(input fp16_t x);
    fp16_op_t o;
`ifdef FP16MUL_SUBNORM_EN
    logic [3:0] z;
`endif
    o.sign = x.sign;
    o.nan  = (x.exp == '1) && (x.frac != '0);
    o.inf  = (x.exp == '1) && (x.frac == '0);
    o.sig  = {1'b1, x.frac};
    o.exp  = {3'b000, x.exp};
`ifdef FP16MUL_SUBNORM_EN
    o.zero = (x.exp == '0) && (x.frac == '0);
    if (x.exp == '0) begin
      z     = lzc11({1'b0, x.frac});
      o.sig = {1'b0, x.frac} << z;
      o.exp = 8'd1 - {4'b0000, z};
    end
`else
    o.zero = (x.exp == '0);
`endif
    return o;
  endfunction

endpackage

// File: rtl/fp16mul_if.sv
// Beat-level valid/ready bundle for the multi-lane FP16 multiplier.
interface fp16mul_if #(
  parameter int unsigned LANES = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [16*LANES-1:0]   in_a;
  logic [16*LANES-1:0]   in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [32*LANES-1:0]   out_p;
  logic [LANES-1:0]      out_inv;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, out_inv
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, out_inv
  );
endinterface

// File: rtl/fp16mul_lane.sv
// Combinational single-lane FP16 x FP16 -> FP32 exact multiply with special-case handling.
// Subnormal behaviour follows FP16MUL_SUBNORM_EN (see fp16mul_pkg).
module fp16mul_lane
  import fp16mul_pkg::*;
(
  input  logic [FP16_W-1:0] a,
  input  logic [FP16_W-1:0] b,
  output logic [FP32_W-1:0] p,
  output logic              inv
);

  fp16_op_t    op_a;
  fp16_op_t    op_b;
  logic        sign;
  logic [21:0] sig;
  logic        n;
  logic [7:0]  exp_sum;
  fp32_t       prod;

  always_comb begin
    op_a    = unpack_fp16(fp16_t'(a));
    op_b    = unpack_fp16(fp16_t'(b));
    sign    = op_a.sign ^ op_b.sign;
    sig     = 22'(op_a.sig) * 22'(op_b.sig);
    n       = sig[21];
    // Modulo-256 sum is exact: the true result always lies within 79..158
    exp_sum = op_a.exp + op_b.exp + BIAS_ADJ + {7'b0, n};
    prod.sign = sign;
    prod.exp  = exp_sum;
    prod.frac = n ? {sig[20:0], 2'b00} : {sig[19:0], 3'b000};

    p   = prod;
    inv = 1'b0;
    if (op_a.nan || op_b.nan) begin
      p   = QNAN32;
      inv = 1'b1;
    end else if ((op_a.inf && op_b.zero) || (op_a.zero && op_b.inf)) begin
      p   = QNAN32;
      inv = 1'b1;
    end else if (op_a.inf || op_b.inf) begin
      p = {sign, 8'hFF, 23'h0};
    end else if (op_a.zero || op_b.zero) begin
      p = {sign, 31'h0};
    end
  end

endmodule

// File: rtl/fp16mul_pipe.sv
// Pipelined multi-lane FP16 x FP16 -> FP32 multiplier with a global valid/ready stall.
// Build option FP16MUL_SUBNORM_EN selects subnormal normalisation over flush-to-zero.
module fp16mul_pipe
  import fp16mul_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned STAGES = 2
) (
  input logic       clk,
  input logic       rst,
  fp16mul_if.slave  bus
);

  logic [FP32_W*LANES-1:0] p_c;
  logic [LANES-1:0]        inv_c;

  logic [STAGES-1:0]       vld_q;
  logic [FP32_W*LANES-1:0] p_q   [STAGES];
  logic [LANES-1:0]        inv_q [STAGES];
  logic                    adv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp16mul_lane u_lane (
      .a   (bus.in_a[FP16_W*i +: FP16_W]),
      .b   (bus.in_b[FP16_W*i +: FP16_W]),
      .p   (p_c[FP32_W*i +: FP32_W]),
      .inv (inv_c[i])
    );
  end

  // Whole pipe moves as one; output-side stall freezes every stage
  assign adv = bus.out_ready || !vld_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        p_q[s]   <= '0;
        inv_q[s] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= bus.in_valid;
      p_q[0]   <= p_c;
      inv_q[0] <= inv_c;
      for (int unsigned s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        p_q[s]   <= p_q[s-1];
        inv_q[s] <= inv_q[s-1];
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_p     = p_q[STAGES-1];
  assign bus.out_inv   = inv_q[STAGES-1];

endmodule

// File: tb/tb_fp16mul_pipe.sv
// Scoreboard bench for fp16mul_pipe: directed spec vectors plus random pairs against a real-valued model.
module tb_fp16mul_pipe;

  localparam int unsigned LANES  = 4;
  localparam int unsigned STAGES = 2;
`ifdef FP16MUL_SUBNORM_EN
  localparam bit SUBN = 1'b1;
`else
  localparam bit SUBN = 1'b0;
`endif

  typedef struct {
    logic [32*LANES-1:0] p;
    logic [LANES-1:0]    inv;
    int                  acc;
    bit                  lat;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   compares = 0;
  int   miscompares = 0;
  bit   rdy_rand = 1'b0;
  ent_t sb[$];

  fp16mul_if #(.LANES(LANES)) bus ();

  fp16mul_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rdy_rand) bus.out_ready = ($urandom % 4) != 0;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compares++;
    if (act !== exp) begin
      $display("FAIL %s: got %h required %h", nm, act, exp);
      miscompares++;
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16_mag(input logic [4:0] e, input logic [9:0] f);
    if (e == 5'd0) return real'(f) * pow2(-24);
    return real'(1024 + int'(f)) * pow2(int'(e) - 25);
  endfunction

  function automatic void ref_mul(input logic [15:0] a, input logic [15:0] b,
                                  output logic [31:0] p, output logic inv);
    logic sa, sb_, s;
    logic [4:0] ea, eb;
    logic [9:0] fa, fb;
    bit na, nb, ia, ib, za, zb;
    real m;
    int e;
    longint fr;
    {sa, ea, fa} = a;
    {sb_, eb, fb} = b;
    s  = sa ^ sb_;
    na = (ea == 5'd31) && (fa != 0);
    nb = (eb == 5'd31) && (fb != 0);
    ia = (ea == 5'd31) && (fa == 0);
    ib = (eb == 5'd31) && (fb == 0);
    za = (ea == 5'd0) && ((fa == 0) || !SUBN);
    zb = (eb == 5'd0) && ((fb == 0) || !SUBN);
    inv = 1'b0;
    if (na || nb)                   begin p = 32'h7FC0_0000; inv = 1'b1; end
    else if ((ia && zb) || (za && ib)) begin p = 32'h7FC0_0000; inv = 1'b1; end
    else if (ia || ib)              p = {s, 8'hFF, 23'h0};
    else if (za || zb)              p = {s, 31'h0};
    else begin
      m = fp16_mag(ea, fa) * fp16_mag(eb, fb);
      e = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      fr = longint'((m - 1.0) * 8388608.0);
      p  = {s, 8'(e + 127), 23'(fr)};
    end
  endfunction

  function automatic ent_t model_beat(input logic [16*LANES-1:0] a, input logic [16*LANES-1:0] b);
    ent_t e;
    logic [31:0] p;
    logic iv;
    e.p = '0; e.inv = '0; e.acc = 0; e.lat = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      ref_mul(a[16*l +: 16], b[16*l +: 16], p, iv);
      e.p[32*l +: 32] = p;
      e.inv[l]        = iv;
    end
    return e;
  endfunction

  function automatic logic [15:0] rnd16();
    logic [4:0] e;
    logic [9:0] f;
    int r = $urandom % 8;
    e = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom);
    f = (($urandom % 4) == 0) ? 10'd0 : 10'($urandom);
    return {1'($urandom), e, f};
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [16*LANES-1:0] a, input logic [16*LANES-1:0] b, input ent_t e);
    int n = 0;
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!acc && n < 300) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc   = 1'b1;
        e.acc = cyc;
        sb.push_back(e);
        vectors++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      $display("FAIL send_timeout: got no in_ready required acceptance within 300 cycles");
      miscompares++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 128'(sb.size()), 128'd0);
  endtask

  function automatic ent_t mk(input logic [127:0] p, input logic [3:0] inv, input bit lat);
    ent_t e;
    e.p = p; e.inv = inv; e.acc = 0; e.lat = lat;
    return e;
  endfunction

  // ---------------- monitor ----------------
  bit                  stall_prev = 1'b0;
  logic [32*LANES-1:0] prev_p;

  always @(negedge clk) begin
    ent_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 128'(bus.out_valid), 128'd1);
        chk("hold_p", 128'(bus.out_p), 128'(prev_p));
      end
      if (bus.out_valid && !bus.out_ready)
        chk("stall_in_ready", 128'(bus.in_ready), 128'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          $display("FAIL unexpected_beat: got p=%h required no beat", bus.out_p);
          miscompares++;
        end else begin
          e = sb.pop_front();
          chk("out_p", 128'(bus.out_p), 128'(e.p));
          chk("out_inv", 128'(bus.out_inv), 128'(e.inv));
          if (e.lat) chk("latency", 128'(cyc - e.acc), 128'(STAGES));
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_p     = bus.out_p;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [16*LANES-1:0] a, b;
    int nfill;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_p", 128'(bus.out_p), 128'd0);
    chk("rst_out_inv", 128'(bus.out_inv), 128'd0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    #1;

    // basics
    send({16'h3C00, 16'h4000, 16'hBE00, 16'h7BFF}, {16'h3C00, 16'h4200, 16'h4000, 16'h7BFF},
         mk({32'h3F80_0000, 32'h40C0_0000, 32'hC040_0000, 32'h4F7F_C004}, 4'b0000, 1'b1));
    // specials
    send({16'h7C00, 16'h7E00, 16'hFC00, 16'h8000}, {16'h0000, 16'h3C00, 16'h3C00, 16'h3C00},
         mk({32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h8000_0000}, 4'b1100, 1'b1));
    // subnormals
    if (SUBN)
      send({16'h0001, 16'h03FF, 16'h8001, 16'h3C00}, {16'h3C00, 16'h3C00, 16'h3C00, 16'h03FF},
           mk({32'h3380_0000, 32'h387F_C000, 32'hB380_0000, 32'h387F_C000}, 4'b0000, 1'b1));
    else
      send({16'h0001, 16'h03FF, 16'h8001, 16'h7C00}, {16'h3C00, 16'h3C00, 16'h3C00, 16'h0200},
           mk({32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000}, 4'b0001, 1'b1));
    drain();

    // backpressure mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          for (int l = 0; l < LANES; l++) begin
            a[16*l +: 16] = 16'h3C00 + 16'(4 * i + l);
            b[16*l +: 16] = 16'h3C00;
          end
          send(a, b, model_beat(a, b));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // reset with beats in flight
    bus.out_ready = 1'b0;
    nfill = (STAGES >= 2) ? 2 : 1;
    for (int i = 0; i < nfill; i++) begin
      a = {4{16'h4400}};
      b = {4{16'h4400}};
      send(a, b, model_beat(a, b));
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("midrst_out_p", 128'(bus.out_p), 128'd0);
    chk("midrst_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (STAGES + 4) @(posedge clk);
    #1;

    // random pairs with random backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      for (int l = 0; l < LANES; l++) begin
        a[16*l +: 16] = rnd16();
        b[16*l +: 16] = rnd16();
      end
      send(a, b, model_beat(a, b));
    end
    rdy_rand = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
